// File: rtl/fleet_pkg.sv
// Shared types and helpers for the alien fleet march controller.
// State enum, march direction and coordinate widths.
package fleet_pkg;

    localparam int COORD_W  = 11;
    localparam int PERIOD_W = 7;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_MARCH,
        ST_LANDED,
        ST_CLEARED
    } fleet_state_t;

    typedef enum logic {
        DIR_RIGHT,
        DIR_LEFT
    } fleet_dir_t;

    // Frames per step: fewer aliens means a faster march.
    function automatic logic [PERIOD_W-1:0] step_period(
        input logic [5:0] alive,
        input int         minPeriod,
        input int         shift
    );
        logic [5:0] scaled;
        scaled = alive >> shift;
        return PERIOD_W'(minPeriod) + PERIOD_W'(scaled);
    endfunction

endpackage

// File: rtl/step_period_timer.sv
// Frame counter that raises stepDue when the march period has elapsed.
// The period is recomputed from aliveCount on every comparison.
module step_period_timer
    import fleet_pkg::*;
#(
    parameter int MIN_PERIOD  = 2,
    parameter int SPEED_SHIFT = 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                startOfFrame,
    input  logic                enable,
    input  logic                clear,
    input  logic [5:0]          aliveCount,
    output logic [PERIOD_W-1:0] frameCount,
    output logic                stepDue
);

    logic [PERIOD_W-1:0] period;
    logic [PERIOD_W-1:0] lastCount;

    // Compare against the current period; a count already past it fires at once.
    always_comb begin
        period    = step_period(aliveCount, MIN_PERIOD, SPEED_SHIFT);
        lastCount = period - PERIOD_W'(1);
        stepDue   = enable && startOfFrame && (frameCount >= lastCount);
    end

    // Count frames while marching; wrap to zero on each step.
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            frameCount <= '0;
        end else if (enable && startOfFrame) begin
            if (stepDue) begin
                frameCount <= '0;
            end else begin
                frameCount <= frameCount + PERIOD_W'(1);
            end
        end
    end

endmodule

// File: rtl/alien_fleet_march_ctrl.sv
// Alien formation sequencer: sideways steps, row drops and reversals.
// Flags landing and wave-clear; all outputs are registered.
module alien_fleet_march_ctrl
    import fleet_pkg::*;
#(
    parameter int INITIAL_X   = 64,
    parameter int INITIAL_Y   = 48,
    parameter int X_STEP      = 8,
    parameter int Y_STEP      = 16,
    parameter int LEFT_LIMIT  = 0,
    parameter int RIGHT_LIMIT = 639,
    parameter int LAND_Y      = 400,
    parameter int MIN_PERIOD  = 2,
    parameter int SPEED_SHIFT = 1
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      startOfFrame,
    input  logic                      enable,
    input  logic                      newWave,
    input  logic [5:0]                aliveCount,
    input  logic [9:0]                minColOffset,
    input  logic [9:0]                maxColOffset,
    output logic signed [COORD_W-1:0] topLeftX,
    output logic signed [COORD_W-1:0] topLeftY,
    output logic                      stepPulse,
    output logic                      animFrame,
    output logic                      landed,
    output logic                      cleared
);

    localparam logic signed [COORD_W-1:0] INIT_X_C = COORD_W'(INITIAL_X);
    localparam logic signed [COORD_W-1:0] INIT_Y_C = COORD_W'(INITIAL_Y);
    localparam logic signed [COORD_W-1:0] X_STEP_C = COORD_W'(X_STEP);
    localparam logic signed [COORD_W-1:0] Y_STEP_C = COORD_W'(Y_STEP);
    localparam logic signed [COORD_W-1:0] LAND_Y_C = COORD_W'(LAND_Y);
    localparam logic signed [11:0]        X_STEP_W = 12'(X_STEP);
    localparam logic signed [11:0]        LEFT_W   = 12'(LEFT_LIMIT);
    localparam logic signed [11:0]        RIGHT_W  = 12'(RIGHT_LIMIT);

    fleet_state_t              state, stateN;
    fleet_dir_t                dir, dirN;
    logic signed [COORD_W-1:0] xN, yN, yDrop;
    logic                      pulseN, animN, landedN, clearedN;
    logic [PERIOD_W-1:0]       frameCount;
    logic                      stepDue;
    logic                      timerRun;
    logic signed [11:0]        xWide, rightEdge, leftEdge;
    logic                      hitRight, hitLeft, doDrop;

    assign timerRun = (state == ST_MARCH) && enable && (aliveCount != 6'd0);

    step_period_timer #(
        .MIN_PERIOD  (MIN_PERIOD),
        .SPEED_SHIFT (SPEED_SHIFT)
    ) u_timer (
        .clk          (clk),
        .reset        (reset),
        .startOfFrame (startOfFrame),
        .enable       (timerRun),
        .clear        (newWave),
        .aliveCount   (aliveCount),
        .frameCount   (frameCount),
        .stepDue      (stepDue)
    );

    // Edge checks in 12-bit signed so extreme offsets cannot wrap.
    always_comb begin
        xWide     = {topLeftX[COORD_W-1], topLeftX};
        rightEdge = xWide + $signed({2'b00, maxColOffset}) + X_STEP_W;
        leftEdge  = xWide + $signed({2'b00, minColOffset}) - X_STEP_W;
        hitRight  = rightEdge > RIGHT_W;
        hitLeft   = leftEdge < LEFT_W;
        doDrop    = (dir == DIR_RIGHT) ? hitRight : hitLeft;
        yDrop     = topLeftY + Y_STEP_C;
    end

    // Next-state and next-output decisions; newWave overrides every state.
    always_comb begin
        stateN   = state;
        dirN     = dir;
        xN       = topLeftX;
        yN       = topLeftY;
        pulseN   = 1'b0;
        animN    = animFrame;
        landedN  = landed;
        clearedN = cleared;
        if (newWave) begin
            stateN   = ST_MARCH;
            dirN     = DIR_RIGHT;
            xN       = INIT_X_C;
            yN       = INIT_Y_C;
            landedN  = 1'b0;
            clearedN = 1'b0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (enable) stateN = ST_MARCH;
                end
                ST_MARCH: begin
                    if (enable && startOfFrame && aliveCount == 6'd0) begin
                        stateN   = ST_CLEARED;
                        clearedN = 1'b1;
                    end else if (stepDue) begin
                        pulseN = 1'b1;
                        animN  = ~animFrame;
                        if (doDrop) begin
                            yN   = yDrop;
                            dirN = (dir == DIR_RIGHT) ? DIR_LEFT : DIR_RIGHT;
                            if (yDrop >= LAND_Y_C) begin
                                stateN  = ST_LANDED;
                                landedN = 1'b1;
                            end
                        end else if (dir == DIR_RIGHT) begin
                            xN = topLeftX + X_STEP_C;
                        end else begin
                            xN = topLeftX - X_STEP_C;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_IDLE;
            dir       <= DIR_RIGHT;
            topLeftX  <= INIT_X_C;
            topLeftY  <= INIT_Y_C;
            stepPulse <= 1'b0;
            animFrame <= 1'b0;
            landed    <= 1'b0;
            cleared   <= 1'b0;
        end else begin
            state     <= stateN;
            dir       <= dirN;
            topLeftX  <= xN;
            topLeftY  <= yN;
            stepPulse <= pulseN;
            animFrame <= animN;
            landed    <= landedN;
            cleared   <= clearedN;
        end
    end

endmodule

// File: tb/tb_alien_fleet_march_ctrl.sv
// Directed bench for alien_fleet_march_ctrl.
// Hand-computed positions, step counts and flags.
module tb_alien_fleet_march_ctrl;
    import fleet_pkg::*;

    logic               clk = 1'b0;
    logic               reset;
    logic               startOfFrame;
    logic               enable;
    logic               newWave;
    logic [5:0]         aliveCount;
    logic [9:0]         minColOffset;
    logic [9:0]         maxColOffset;
    logic signed [10:0] topLeftX;
    logic signed [10:0] topLeftY;
    logic               stepPulse;
    logic               animFrame;
    logic               landed;
    logic               cleared;

    int nChk  = 0;
    int nPass = 0;
    int steps = 0;

    alien_fleet_march_ctrl dut (
        .clk          (clk),
        .reset        (reset),
        .startOfFrame (startOfFrame),
        .enable       (enable),
        .newWave      (newWave),
        .aliveCount   (aliveCount),
        .minColOffset (minColOffset),
        .maxColOffset (maxColOffset),
        .topLeftX     (topLeftX),
        .topLeftY     (topLeftY),
        .stepPulse    (stepPulse),
        .animFrame    (animFrame),
        .landed       (landed),
        .cleared      (cleared)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        nChk++;
        if (obs == exp) nPass++;
        else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One frame pulse followed by a gap cycle; counts observed steps.
    task automatic frames(input int n);
        for (int i = 0; i < n; i++) begin
            startOfFrame = 1'b1;
            tick();
            startOfFrame = 1'b0;
            steps += int'(stepPulse);
            tick();
        end
    endtask

    task automatic wave();
        newWave = 1'b1;
        tick();
        newWave = 1'b0;
    endtask

    initial begin
        reset        = 1'b1;
        startOfFrame = 1'b0;
        enable       = 1'b0;
        newWave      = 1'b0;
        aliveCount   = 6'd40;
        minColOffset = 10'd0;
        maxColOffset = 10'd100;
        tick();
        tick();
        chk("rst_x", topLeftX, 64);
        chk("rst_y", topLeftY, 48);
        chk("rst_pulse", stepPulse, 0);
        chk("rst_anim", animFrame, 0);
        chk("rst_landed", landed, 0);
        chk("rst_cleared", cleared, 0);
        chk("rst_state", dut.state, ST_IDLE);

        // Basic step, period 22
        reset  = 1'b0;
        enable = 1'b1;
        tick();
        chk("idle_to_march", dut.state, ST_MARCH);
        steps = 0;
        frames(21);
        chk("t1_x_before", topLeftX, 64);
        chk("t1_steps_before", steps, 0);
        frames(1);
        chk("t1_x", topLeftX, 72);
        chk("t1_steps", steps, 1);
        chk("t1_anim", animFrame, 1);

        // Right-edge drop, period 2
        wave();
        chk("t2_wave_x", topLeftX, 64);
        aliveCount   = 6'd1;
        maxColOffset = 10'd560;
        frames(2);
        chk("t2_s1_x", topLeftX, 72);
        frames(2);
        chk("t2_s2_x", topLeftX, 72);
        chk("t2_s2_y", topLeftY, 64);
        frames(2);
        chk("t2_s3_x", topLeftX, 64);
        chk("t2_s3_y", topLeftY, 64);

        // newWave collides with a due step
        wave();
        maxColOffset = 10'd100;
        frames(2);
        chk("t5_pre_x", topLeftX, 72);
        frames(1);
        startOfFrame = 1'b1;
        newWave      = 1'b1;
        tick();
        startOfFrame = 1'b0;
        newWave      = 1'b0;
        chk("t5_x", topLeftX, 64);
        chk("t5_y", topLeftY, 48);
        chk("t5_pulse", stepPulse, 0);
        chk("t5_cnt", dut.frameCount, 0);
        steps = 0;
        frames(1);
        chk("t5_restart_nostep", steps, 0);
        frames(1);
        chk("t5_restart_step", steps, 1);
        chk("t5_restart_x", topLeftX, 72);

        // Landing: walk to X=0, then every step drops
        wave();
        maxColOffset = 10'd1000;
        steps = 0;
        frames(60);
        chk("t3_steps", steps, 30);
        chk("t3_x", topLeftX, 0);
        chk("t3_y", topLeftY, 400);
        chk("t3_landed", landed, 1);
        chk("t3_state", dut.state, ST_LANDED);
        steps = 0;
        frames(4);
        chk("t3_hold_steps", steps, 0);
        chk("t3_hold_y", topLeftY, 400);
        chk("t3_hold_landed", landed, 1);

        // Speed-up then clear
        wave();
        chk("t4_landed_clr", landed, 0);
        maxColOffset = 10'd100;
        aliveCount   = 6'd2;
        steps = 0;
        frames(1);
        aliveCount = 6'd1;
        frames(1);
        chk("t4_speedup_steps", steps, 1);
        chk("t4_speedup_x", topLeftX, 72);
        aliveCount = 6'd0;
        steps = 0;
        frames(1);
        chk("t4_cleared", cleared, 1);
        chk("t4_state", dut.state, ST_CLEARED);
        frames(2);
        chk("t4_no_steps", steps, 0);
        chk("t4_hold_x", topLeftX, 72);

        // Enable freeze, then overshoot of a shortened period
        wave();
        chk("t6_cleared_clr", cleared, 0);
        aliveCount = 6'd40;
        frames(3);
        chk("t6_cnt", dut.frameCount, 3);
        enable = 1'b0;
        steps = 0;
        frames(10);
        chk("t6_freeze_cnt", dut.frameCount, 3);
        chk("t6_freeze_x", topLeftX, 64);
        chk("t6_freeze_steps", steps, 0);
        enable     = 1'b1;
        aliveCount = 6'd1;
        frames(1);
        chk("t6_overshoot_steps", steps, 1);
        chk("t6_overshoot_x", topLeftX, 72);

        // Reset mid-march with a frame pulse present
        frames(1);
        reset        = 1'b1;
        startOfFrame = 1'b1;
        tick();
        reset        = 1'b0;
        startOfFrame = 1'b0;
        chk("t6_rst_x", topLeftX, 64);
        chk("t6_rst_y", topLeftY, 48);
        chk("t6_rst_state", dut.state, ST_IDLE);
        chk("t6_rst_pulse", stepPulse, 0);
        chk("t6_rst_cnt", dut.frameCount, 0);

        $display("%0d/%0d checks passed", nPass, nChk);
        $finish;
    end

endmodule
